jtag_led_ctrl: RTL
==================

JTAG_LED_CTRL -- requirements
Module: jtag_led_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, giving clocks per base tick (legal >= 2).
REQ-002 SHALL have parameter LED_ACTIVE_LOW, default 1; 1 means led = inverted internal pattern.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command word present on cmd_data.
REQ-006 SHALL have port cmd_ready, output, 1 bit: block can accept a command this cycle.
REQ-007 SHALL have port cmd_data, input, 8 bits: opcode [7:6] and argument [5:0].
REQ-008 SHALL have port led, output, 4 bits: LED drive, polarity per LED_ACTIVE_LOW.
REQ-009 SHALL have port status, output, 8 bits: {mode[1:0], rate[5:0]} readback for the JTAG capture path.

Function
REQ-010 Handshake: a command SHALL be accepted on a rising edge when cmd_valid && cmd_ready; cmd_data is sampled only then.
REQ-011 cmd_ready SHALL drop for exactly one cycle after each accept (DECODE cycle), then return high; cmd_valid while cmd_ready=0 SHALL be ignored, not queued.
REQ-012 Opcode 00 SET: mode=STATIC, pattern=cmd_data[3:0].
REQ-013 Opcode 01 BLINK: mode=BLINK, pattern=cmd_data[3:0], phase=on.
REQ-014 Opcode 10 CHASE: mode=CHASE, pattern=4'b0001, dir=cmd_data[0] (0 = toward MSB, 1 = toward LSB).
REQ-015 Opcode 11 RATE: rate=cmd_data[5:0], with 0 stored as 1; mode, pattern and phase unchanged; step counter cleared.
REQ-016 Latency: accept at edge N, decode at edge N+1, led reflects the new state after edge N+1 (registered output).
REQ-017 Prescaler: count 0..CLK_DIV-1 then wrap; base tick pulses for one cycle when count == CLK_DIV-1; runs free in every mode.
REQ-018 Step counter: increments on each tick; when it reaches rate on a tick, a one-cycle step event fires and the counter clears, giving one step per rate*CLK_DIV clocks.
REQ-019 Any decoded SET, BLINK or CHASE SHALL clear the step counter and the prescaler so the first step lands a full period after decode.
REQ-020 Mode FSM states STATIC, BLINK, CHASE; transitions only on decoded commands; any state can go to any state.
REQ-021 STATIC: internal output = pattern; step events ignored.
REQ-022 BLINK: phase toggles on each step; internal output = phase ? pattern : 4'b0000.
REQ-023 CHASE: on each step, pattern rotates by one (dir 0: 0001->0010->0100->1000->0001; dir 1 reverse), wrapping at the ends.
REQ-024 led SHALL be ~internal output when LED_ACTIVE_LOW=1, otherwise internal output.
REQ-025 A command decoded in the same cycle as a step event SHALL win; that step is discarded.
REQ-026 status SHALL update in the cycle after decode; mode encoding STATIC=00, BLINK=01, CHASE=10.

Reset
REQ-027 While rst=1: mode=STATIC, pattern=0, phase=on, dir=0, rate=1, prescaler=0, step counter=0, cmd_ready=0; led=4'b1111 (active-low); status=8'h01.
REQ-028 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 rst asserted mid-command (during DECODE) SHALL discard that command completely.

Verification (CLK_DIV=4)
REQ-030 Reset release, no commands -> led=4'b1111, status=8'h01, cmd_ready=1 on the first post-reset cycle.
REQ-031 SET 8'h05 accepted at edge N -> cmd_ready=0 for one cycle; led=4'b1010 after edge N+1; status=8'h01.
REQ-032 RATE 8'hC2, then BLINK 8'h4F -> led alternates 4'b0000 / 4'b1111 every 8 clocks; status=8'h42.
REQ-033 RATE 8'hC0, then CHASE 8'h80 -> led steps 1110, 1101, 1011, 0111, 1110, one step every 4 clocks; CHASE 8'h81 -> same sequence in reverse order.
REQ-034 cmd_valid held high continuously with alternating words -> accepts occur on every second cycle only; no word is accepted during DECODE.
REQ-035 rst pulsed during CHASE, including the DECODE cycle of a pending SET -> after reset, state equals REQ-027 and the pending SET has no effect.

Source files
------------

// File: rtl/jtag_led_ctrl.sv
// LED pattern controller fed by 8-bit command words from a JTAG data register.
// Supports static, blinking and chasing patterns with a programmable step rate.
module jtag_led_ctrl #(
    parameter int unsigned CLK_DIV        = 1000,
    parameter int unsigned LED_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic [3:0] led,
    output logic [7:0] status
);

    typedef enum logic [1:0] {
        ModeStatic = 2'b00,
        ModeBlink  = 2'b01,
        ModeChase  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        OpSet   = 2'b00,
        OpBlink = 2'b01,
        OpChase = 2'b10,
        OpRate  = 2'b11
    } op_e;

    localparam int unsigned   PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    // XOR mask applied to the internal pattern to get the pin drive.
    localparam logic [3:0]    LED_MASK  = (LED_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic          decode_q;
    logic [7:0]    cmd_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    step_cnt_q, step_cnt_d;
    logic [5:0]    rate_q, rate_d;
    mode_e         mode_q, mode_d;
    logic [3:0]    pattern_q, pattern_d;
    logic          phase_q, phase_d;
    logic          dir_q, dir_d;
    logic [3:0]    led_q;
    logic [3:0]    internal_d;

    logic          accept;
    logic          tick;
    logic          step;
    op_e           opcode;
    logic [5:0]    arg;

    assign cmd_ready = ~rst & ~decode_q;
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (presc_q == PRESC_MAX);
    assign step      = tick & (step_cnt_q == (rate_q - 6'd1));
    assign opcode    = op_e'(cmd_q[7:6]);
    assign arg       = cmd_q[5:0];

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PRESC_ONE;
        step_cnt_d = step_cnt_q;
        if (tick) begin
            step_cnt_d = step ? 6'd0 : step_cnt_q + 6'd1;
        end
        rate_d    = rate_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        phase_d   = phase_q;
        dir_d     = dir_q;

        // A decoded command always wins over a coincident step event.
        if (decode_q) begin
            step_cnt_d = '0;
            unique case (opcode)
                OpSet: begin
                    mode_d    = ModeStatic;
                    pattern_d = arg[3:0];
                    presc_d   = '0;
                end
                OpBlink: begin
                    mode_d    = ModeBlink;
                    pattern_d = arg[3:0];
                    phase_d   = 1'b1;
                    presc_d   = '0;
                end
                OpChase: begin
                    mode_d    = ModeChase;
                    pattern_d = 4'b0001;
                    dir_d     = arg[0];
                    presc_d   = '0;
                end
                OpRate: begin
                    rate_d = (arg == 6'd0) ? 6'd1 : arg;
                end
                default: ;
            endcase
        end else if (step) begin
            case (mode_q)
                ModeBlink: phase_d = ~phase_q;
                ModeChase: pattern_d = dir_q ? {pattern_q[0], pattern_q[3:1]}
                                             : {pattern_q[2:0], pattern_q[3]};
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_d)
            ModeBlink: internal_d = phase_d ? pattern_d : 4'b0000;
            default:   internal_d = pattern_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decode_q   <= 1'b0;
            cmd_q      <= '0;
            presc_q    <= '0;
            step_cnt_q <= '0;
            rate_q     <= 6'd1;
            mode_q     <= ModeStatic;
            pattern_q  <= '0;
            phase_q    <= 1'b1;
            dir_q      <= 1'b0;
            led_q      <= LED_MASK;
        end else begin
            decode_q <= accept;
            if (accept) begin
                cmd_q <= cmd_data;
            end
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            rate_q     <= rate_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            phase_q    <= phase_d;
            dir_q      <= dir_d;
            led_q      <= internal_d ^ LED_MASK;
        end
    end

    assign led    = led_q;
    assign status = {mode_q, rate_q};

endmodule
